// File: rtl/des_core_scheduler.sv
// Round scheduler for a shared iterative DES datapath: round-robin arbitration between
// encipher and decipher requesters, load/round/final sequencing and an owner-tagged result handshake.
module des_core_scheduler #(
  parameter int NUM_ROUNDS = 16,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             enc_valid,
  output logic             enc_ready,
  input  logic             dec_valid,
  output logic             dec_ready,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic             dp_decrypt,
  output logic [1:0]       ks_shift_amt,
  output logic             dp_final,
  output logic             out_valid,
  output logic             out_owner,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  state_t           state_r, state_s;
  logic             last_owner_r, last_owner_s;
  logic [IDX_W-1:0] cnt_r, cnt_s;
  logic             load_r, load_s;
  logic             round_en_r, round_en_s;
  logic             final_r, final_s;
  logic [1:0]       shift_r, shift_s;
  logic             decrypt_r, decrypt_s;
  logic             ovalid_r, ovalid_s;
  logic             owner_r, owner_s;
  logic             busy_r, busy_s;

  // Decipher runs the key schedule backwards, so its first round uses no rotation.
  function automatic logic [1:0] shift_amt(input logic [IDX_W-1:0] idx, input logic dec);
    logic [31:0] i;
    i = 32'(idx);
    if (dec && (i == 32'd0)) begin
      return 2'd0;
    end else if ((i == 32'd0) || (i == 32'd1) || (i == 32'd8) || (i == 32'd15)) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

  assign enc_ready = (state_r == S_IDLE) && !clr && (last_owner_r || !dec_valid);
  assign dec_ready = (state_r == S_IDLE) && !clr && (!last_owner_r || !enc_valid);

  // Next-state and next-output decode; all outputs are registered one cycle later.
  always_comb begin
    state_s      = state_r;
    last_owner_s = last_owner_r;
    cnt_s        = cnt_r;
    load_s       = 1'b0;
    round_en_s   = 1'b0;
    final_s      = 1'b0;
    shift_s      = 2'd0;
    decrypt_s    = decrypt_r;
    owner_s      = owner_r;
    ovalid_s     = ovalid_r;
    if (clr) begin
      state_s  = S_IDLE;
      cnt_s    = {IDX_W{1'b0}};
      ovalid_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_s    = {IDX_W{1'b0}};
          ovalid_s = 1'b0;
          if (enc_valid && enc_ready) begin
            state_s      = S_LOAD;
            load_s       = 1'b1;
            decrypt_s    = 1'b0;
            owner_s      = 1'b0;
            last_owner_s = 1'b0;
          end else if (dec_valid && dec_ready) begin
            state_s      = S_LOAD;
            load_s       = 1'b1;
            decrypt_s    = 1'b1;
            owner_s      = 1'b1;
            last_owner_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LOAD: begin
          state_s    = S_ROUND;
          cnt_s      = {IDX_W{1'b0}};
          round_en_s = 1'b1;
          final_s    = (LAST_IDX == {IDX_W{1'b0}});
          shift_s    = shift_amt({IDX_W{1'b0}}, decrypt_r);
        end
        S_ROUND: begin
          if (cnt_r == LAST_IDX) begin
            state_s  = S_DONE;
            cnt_s    = {IDX_W{1'b0}};
            ovalid_s = 1'b1;
          end else begin
            cnt_s      = cnt_r + IDX_W'(1);
            round_en_s = 1'b1;
            final_s    = (cnt_s == LAST_IDX);
            shift_s    = shift_amt(cnt_s, decrypt_r);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_s  = S_IDLE;
            ovalid_s = 1'b0;
          end else begin
            state_s = S_DONE;
          end
        end
        default: begin
          state_s  = S_IDLE;
          cnt_s    = {IDX_W{1'b0}};
          ovalid_s = 1'b0;
        end
      endcase
    end
    busy_s = (state_s != S_IDLE);
  end

  // State, arbitration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      last_owner_r <= 1'b1;
      cnt_r        <= {IDX_W{1'b0}};
      load_r       <= 1'b0;
      round_en_r   <= 1'b0;
      final_r      <= 1'b0;
      shift_r      <= 2'd0;
      decrypt_r    <= 1'b0;
      ovalid_r     <= 1'b0;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_owner_r <= last_owner_s;
      cnt_r        <= cnt_s;
      load_r       <= load_s;
      round_en_r   <= round_en_s;
      final_r      <= final_s;
      shift_r      <= shift_s;
      decrypt_r    <= decrypt_s;
      ovalid_r     <= ovalid_s;
      owner_r      <= owner_s;
      busy_r       <= busy_s;
    end
  end

  assign dp_load      = load_r;
  assign dp_round_en  = round_en_r;
  assign dp_round_idx = cnt_r;
  assign dp_final     = final_r;
  assign ks_shift_amt = shift_r;
  assign dp_decrypt   = decrypt_r;
  assign out_valid    = ovalid_r;
  assign out_owner    = owner_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_des_core_scheduler.sv
// Self-checking bench for des_core_scheduler: directed scenarios plus randomized traffic
// compared against an operation-age reference model.
module tb_des_core_scheduler;
  localparam int NR = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n, clr, enc_valid, dec_valid, out_ready;
  logic enc_ready, dec_ready, dp_load, dp_round_en, dp_decrypt, dp_final;
  logic out_valid, out_owner, busy;
  logic [IW-1:0] dp_round_idx;
  logic [1:0]    ks_shift_amt;

  int total = 0;
  int bad   = 0;

  // Reference model: m_age = -1 idle, 0 load, 1..NR round (idx = age-1), NR+1 result held.
  int   m_age;
  logic m_last, m_dec;
  logic e_load, e_ren, e_fin, e_ov, e_busy, e_er, e_dr;
  logic [IW-1:0] e_idx;
  logic [1:0]    e_shift;
  logic [1:0] enc_tab [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] dec_tab [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  des_core_scheduler #(.NUM_ROUNDS(NR), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .enc_valid(enc_valid), .enc_ready(enc_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
    .dp_decrypt(dp_decrypt), .ks_shift_amt(ks_shift_amt), .dp_final(dp_final),
    .out_valid(out_valid), .out_owner(out_owner), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_age  = -1;
    m_last = 1'b1;
    m_dec  = 1'b0;
  endtask

  task automatic model_eval();
    e_load  = (m_age == 0);
    e_ren   = (m_age >= 1) && (m_age <= NR);
    e_fin   = (m_age == NR);
    e_ov    = (m_age == NR + 1);
    e_busy  = (m_age >= 0);
    e_idx   = 4'd0;
    e_shift = 2'd0;
    if (e_ren) begin
      e_idx   = IW'(m_age - 1);
      e_shift = m_dec ? dec_tab[m_age-1] : enc_tab[m_age-1];
    end
    e_er = (m_age < 0) && !clr && (m_last || !dec_valid);
    e_dr = (m_age < 0) && !clr && (!m_last || !enc_valid);
  endtask

  // Advance one clock edge and the model with the inputs currently applied.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (clr) m_age = -1;
    else if (m_age < 0) begin
      if (enc_valid && e_er) begin m_age = 0; m_dec = 1'b0; m_last = 1'b0; end
      else if (dec_valid && e_dr) begin m_age = 0; m_dec = 1'b1; m_last = 1'b1; end
    end else if (m_age <= NR) m_age++;
    else if (out_ready) m_age = -1;
    #1;
  endtask

  task automatic drain();
    enc_valid = 1'b0; dec_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_age < 0) break;
      tick();
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dp_load, dp_round_en, dp_round_idx, dp_decrypt, ks_shift_amt, dp_final,
         out_valid, out_owner, busy} !== 13'd0) begin
      bad++; $display("FAIL reset_outputs got=%b want all 0", {dp_load, dp_round_en, dp_round_idx,
        dp_decrypt, ks_shift_amt, dp_final, out_valid, out_owner, busy});
    end
    total++;
    if ({enc_ready, dec_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_readies got=%b want 11", {enc_ready, dec_ready});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_ops();
    for (int d = 0; d < 2; d++) begin
      enc_valid = (d == 0); dec_valid = (d == 1); out_ready = 1'b1;
      #1; model_eval();
      total++;
      if ({enc_ready, dec_ready} !== {e_er, e_dr}) begin
        bad++; $display("FAIL single_ready dir=%0d got=%b want=%b", d, {enc_ready, dec_ready}, {e_er, e_dr});
      end
      tick();
      enc_valid = 1'b0; dec_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        model_eval();
        total++;
        if ({dp_load, dp_round_en, dp_final, out_valid, busy} !== {e_load, e_ren, e_fin, e_ov, e_busy}) begin
          bad++; $display("FAIL single_ctl dir=%0d cyc=%0d got=%b want=%b", d, c,
            {dp_load, dp_round_en, dp_final, out_valid, busy}, {e_load, e_ren, e_fin, e_ov, e_busy});
        end
        total++;
        if (ks_shift_amt !== e_shift) begin
          bad++; $display("FAIL single_shift dir=%0d cyc=%0d got=%0d want=%0d", d, c, ks_shift_amt, e_shift);
        end
        if (e_ren) begin
          total++;
          if (dp_round_idx !== e_idx) begin
            bad++; $display("FAIL single_idx dir=%0d cyc=%0d got=%0d want=%0d", d, c, dp_round_idx, e_idx);
          end
        end
        total++;
        if ({dp_decrypt, out_owner} !== {d[0], d[0]}) begin
          bad++; $display("FAIL single_dir dir=%0d cyc=%0d got=%b", d, c, {dp_decrypt, out_owner});
        end
        tick();
      end
    end
  endtask

  task automatic test_tie();
    int grants[$];
    rst_n = 1'b0; model_reset();
    enc_valid = 1'b1; dec_valid = 1'b1; out_ready = 1'b1; clr = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 80; c++) begin
      model_eval();
      total++;
      if ((enc_ready && dec_ready) || ({enc_ready, dec_ready} !== {e_er, e_dr})) begin
        bad++; $display("FAIL tie_ready cyc=%0d got=%b want=%b", c, {enc_ready, dec_ready}, {e_er, e_dr});
      end
      if (enc_ready) grants.push_back(0);
      else if (dec_ready) grants.push_back(1);
      tick();
    end
    total++;
    if (grants.size() < 4) begin
      bad++; $display("FAIL tie_count got=%0d want>=4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grants[i] != (i % 2)) begin
          bad++; $display("FAIL tie_order n=%0d got=%0d want=%0d", i, grants[i], i % 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    enc_valid = 1'b1; dec_valid = 1'b0; out_ready = 1'b0;
    tick();
    enc_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin seen = 1'b1; break; end
      tick();
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_timeout out_valid=%b want 1", out_valid); end
    dec_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if ({out_valid, out_owner, busy, enc_ready, dec_ready} !== 5'b10100) begin
        bad++; $display("FAIL bp_hold k=%0d got=%b want=10100", k,
          {out_valid, out_owner, busy, enc_ready, dec_ready});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (dec_ready !== 1'b0) begin bad++; $display("FAIL bp_take_ready got=%b want 0", dec_ready); end
    tick();
    total++;
    if ({out_valid, busy, dec_ready} !== 3'b001) begin
      bad++; $display("FAIL bp_release got=%b want=001", {out_valid, busy, dec_ready});
    end
    tick();
    total++;
    if ({dp_load, dp_decrypt} !== 2'b11) begin
      bad++; $display("FAIL bp_next_grant got=%b want=11", {dp_load, dp_decrypt});
    end
    drain();
  endtask

  task automatic test_clr();
    bit seen = 1'b0;
    clr = 1'b1; enc_valid = 1'b1; dec_valid = 1'b0;
    #1;
    total++;
    if ({enc_ready, dec_ready} !== 2'b00) begin
      bad++; $display("FAIL clr_idle_ready got=%b want=00", {enc_ready, dec_ready});
    end
    tick();
    clr = 1'b0;
    total++;
    if ({busy, dp_load} !== 2'b00) begin bad++; $display("FAIL clr_idle_nogrant got=%b want=00", {busy, dp_load}); end
    tick();
    enc_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dp_round_en && dp_round_idx == 4'd7) begin seen = 1'b1; break; end
      tick();
    end
    total++;
    if (!seen) begin bad++; $display("FAIL clr_timeout idx=%0d want 7", dp_round_idx); end
    clr = 1'b1; enc_valid = 1'b1; dec_valid = 1'b1;
    #1;
    total++;
    if ({enc_ready, dec_ready} !== 2'b00) begin
      bad++; $display("FAIL clr_ready got=%b want=00", {enc_ready, dec_ready});
    end
    tick();
    clr = 1'b0;
    #1;
    total++;
    if ({dp_round_en, out_valid, busy, dp_load, dp_final} !== 5'b00000) begin
      bad++; $display("FAIL clr_abort got=%b want=00000", {dp_round_en, out_valid, busy, dp_load, dp_final});
    end
    total++;
    if ({enc_ready, dec_ready} !== 2'b01) begin
      bad++; $display("FAIL clr_last_owner got=%b want=01", {enc_ready, dec_ready});
    end
    tick();
    total++;
    if ({dp_load, dp_decrypt, out_owner} !== 3'b111) begin
      bad++; $display("FAIL clr_dec_grant got=%b want=111", {dp_load, dp_decrypt, out_owner});
    end
    drain();
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    enc_valid = 1'b1; dec_valid = 1'b0; out_ready = 1'b1;
    tick();
    enc_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dp_round_en && dp_round_idx == 4'd5) begin seen = 1'b1; break; end
      tick();
    end
    total++;
    if (!seen) begin bad++; $display("FAIL arst_timeout idx=%0d want 5", dp_round_idx); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dp_load, dp_round_en, dp_round_idx, dp_decrypt, ks_shift_amt, dp_final,
         out_valid, out_owner, busy} !== 13'd0) begin
      bad++; $display("FAIL arst_outputs got=%b want all 0", {dp_load, dp_round_en, dp_round_idx,
        dp_decrypt, ks_shift_amt, dp_final, out_valid, out_owner, busy});
    end
    model_reset();
    enc_valid = 1'b1; dec_valid = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    #1;
    total++;
    if ({enc_ready, dec_ready} !== 2'b10) begin
      bad++; $display("FAIL arst_tie got=%b want=10", {enc_ready, dec_ready});
    end
    tick();
    enc_valid = 1'b0; dec_valid = 1'b0;
    total++;
    if ({dp_load, dp_decrypt, out_owner} !== 3'b100) begin
      bad++; $display("FAIL arst_enc_grant got=%b want=100", {dp_load, dp_decrypt, out_owner});
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      enc_valid = ($urandom_range(0, 2) != 0);
      dec_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      #1; model_eval();
      total++;
      if ({enc_ready, dec_ready} !== {e_er, e_dr}) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, {enc_ready, dec_ready}, {e_er, e_dr});
      end
      total++;
      if ({dp_load, dp_round_en, dp_final, out_valid, busy, dp_decrypt, out_owner} !==
          {e_load, e_ren, e_fin, e_ov, e_busy, m_dec, m_dec}) begin
        bad++; $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", c,
          {dp_load, dp_round_en, dp_final, out_valid, busy, dp_decrypt, out_owner},
          {e_load, e_ren, e_fin, e_ov, e_busy, m_dec, m_dec});
      end
      total++;
      if (ks_shift_amt !== e_shift) begin
        bad++; $display("FAIL rnd_shift cyc=%0d got=%0d want=%0d", c, ks_shift_amt, e_shift);
      end
      if (e_ren) begin
        total++;
        if (dp_round_idx !== e_idx) begin
          bad++; $display("FAIL rnd_idx cyc=%0d got=%0d want=%0d", c, dp_round_idx, e_idx);
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_tie();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
